// File: rtl/trigger_pulse_shaper_if.sv
// Bundle of trigger, configuration and status signals for trigger_pulse_shaper.
// The master drives trigger and configuration. The slave (the shaper) drives the
// shaped pulse and the status outputs.
interface trigger_pulse_shaper_if #(
    parameter int CNT_W  = 32,
    parameter int MISS_W = 16
);
    logic              i_trig_in;
    logic              i_arm_en;
    logic [CNT_W-1:0]  i_cfg_width;
    logic [CNT_W-1:0]  i_cfg_holdoff;
    logic [7:0]        i_cfg_burst_count;
    logic [CNT_W-1:0]  i_cfg_burst_gap;
    logic              i_cfg_update;
    logic              i_clr_missed;
    logic              o_pulse_out;
    logic              o_busy;
    logic [MISS_W-1:0] o_missed_count;

    modport master (
        output i_trig_in, i_arm_en, i_cfg_width, i_cfg_holdoff,
               i_cfg_burst_count, i_cfg_burst_gap, i_cfg_update, i_clr_missed,
        input  o_pulse_out, o_busy, o_missed_count
    );

    modport slave (
        input  i_trig_in, i_arm_en, i_cfg_width, i_cfg_holdoff,
               i_cfg_burst_count, i_cfg_burst_gap, i_cfg_update, i_clr_missed,
        output o_pulse_out, o_busy, o_missed_count
    );
endinterface

// File: rtl/trigger_pulse_shaper.sv
// Trigger pulse shaper. Each accepted trigger produces a pulse of programmable width.
// A dead time (holdoff) follows the last pulse.
// Triggers that arrive while a sequence is running are dropped and counted.
// Configuration is taken from shadow registers, which are loaded by a strobe and
// copied to active registers when a trigger is accepted.
// Optional feature macro: TRIGGER_PULSE_BURST_EN enables multi-pulse bursts
// (GAP state and burst counter). Without it, every trigger yields exactly one pulse.
module trigger_pulse_shaper #(
    parameter int CNT_W  = 32,
    parameter int MISS_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    trigger_pulse_shaper_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HIGH    = 2'd1,
`ifdef TRIGGER_PULSE_BURST_EN
        S_GAP     = 2'd2,
`endif
        S_HOLDOFF = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_pulse_out, w_pulse_nxt;
    logic              w_load_act;
    logic [CNT_W-1:0]  r_shd_width, r_shd_holdoff;
    logic [CNT_W-1:0]  r_act_width, r_act_holdoff;
    logic [MISS_W-1:0] r_missed;
    logic              w_miss;

`ifdef TRIGGER_PULSE_BURST_EN
    logic [7:0]        r_shd_burst, r_burst_left, w_burst_nxt;
    logic [CNT_W-1:0]  r_shd_gap, r_act_gap;
`else
    logic              w_unused_cfg;
    assign w_unused_cfg = ^{bus.i_cfg_burst_count, bus.i_cfg_burst_gap};
`endif

    // Shadow registers: load sanitised configuration on the update strobe.
    // Zero values are replaced with 1 here, so every counter load below is at least 0.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments, so all flops sample
        // their inputs from the same cycle and do not depend on statement order.
        if (rst) begin
            r_shd_width   <= CNT_ONE;
            r_shd_holdoff <= '0;
`ifdef TRIGGER_PULSE_BURST_EN
            r_shd_burst   <= 8'd1;
            r_shd_gap     <= CNT_ONE;
`endif
        end else if (bus.i_cfg_update) begin
            r_shd_width   <= (bus.i_cfg_width == '0) ? CNT_ONE : bus.i_cfg_width;
            r_shd_holdoff <= bus.i_cfg_holdoff;
`ifdef TRIGGER_PULSE_BURST_EN
            r_shd_burst   <= (bus.i_cfg_burst_count == 8'd0) ? 8'd1 : bus.i_cfg_burst_count;
            r_shd_gap     <= (bus.i_cfg_burst_gap == '0) ? CNT_ONE : bus.i_cfg_burst_gap;
`endif
        end
    end

    // Active registers: freeze the shadow values for the sequence being started.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_act_width   <= CNT_ONE;
            r_act_holdoff <= '0;
`ifdef TRIGGER_PULSE_BURST_EN
            r_act_gap     <= CNT_ONE;
`endif
        end else if (w_load_act) begin
            r_act_width   <= r_shd_width;
            r_act_holdoff <= r_shd_holdoff;
`ifdef TRIGGER_PULSE_BURST_EN
            r_act_gap     <= r_shd_gap;
`endif
        end
    end

    // FSM state, shared phase counter, burst counter and registered pulse output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_pulse_out  <= 1'b0;
`ifdef TRIGGER_PULSE_BURST_EN
            r_burst_left <= 8'd0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_pulse_out  <= w_pulse_nxt;
`ifdef TRIGGER_PULSE_BURST_EN
            r_burst_left <= w_burst_nxt;
`endif
        end
    end

    // Next-state logic. A single counter times the width, gap and holdoff phases
    // down to a terminal value of 0.
    always_comb begin
        // NOTE: every signal gets a default before the case statement, so no path
        // leaves it unassigned and no latch is inferred.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pulse_nxt = 1'b0;
        w_load_act  = 1'b0;
`ifdef TRIGGER_PULSE_BURST_EN
        w_burst_nxt = r_burst_left;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.i_trig_in && bus.i_arm_en) begin
                    w_load_act  = 1'b1;
                    w_pulse_nxt = 1'b1;
                    w_state_nxt = S_HIGH;
                    w_cnt_nxt   = r_shd_width - CNT_ONE;
`ifdef TRIGGER_PULSE_BURST_EN
                    w_burst_nxt = r_shd_burst - 8'd1;
`endif
                end
            end
            S_HIGH: begin
                if (r_cnt == '0) begin
`ifdef TRIGGER_PULSE_BURST_EN
                    if (r_burst_left != 8'd0) begin
                        w_state_nxt = S_GAP;
                        w_cnt_nxt   = r_act_gap - CNT_ONE;
                    end else
`endif
                    if (r_act_holdoff != '0) begin
                        w_state_nxt = S_HOLDOFF;
                        w_cnt_nxt   = r_act_holdoff - CNT_ONE;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_pulse_nxt = 1'b1;
                    w_cnt_nxt   = r_cnt - CNT_ONE;
                end
            end
`ifdef TRIGGER_PULSE_BURST_EN
            S_GAP: begin
                if (r_cnt == '0) begin
                    w_pulse_nxt = 1'b1;
                    w_state_nxt = S_HIGH;
                    w_cnt_nxt   = r_act_width - CNT_ONE;
                    w_burst_nxt = r_burst_left - 8'd1;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_ONE;
                end
            end
`endif
            S_HOLDOFF: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // A trigger outside IDLE is a miss, whatever the state of arm_en.
    assign w_miss = bus.i_trig_in && (r_state != S_IDLE);

    // Missed-trigger counter: saturating. A clear wins over a coincident miss.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_missed <= '0;
        end else if (bus.i_clr_missed) begin
            r_missed <= '0;
        end else if (w_miss && (r_missed != '1)) begin
            r_missed <= r_missed + MISS_W'(1);
        end
    end

    assign bus.o_pulse_out    = r_pulse_out;
    assign bus.o_busy         = (r_state != S_IDLE);
    assign bus.o_missed_count = r_missed;
endmodule

// File: tb/tb_trigger_pulse_shaper.sv
// Self-checking bench for trigger_pulse_shaper.
// Each scenario fills a per-cycle stimulus plan and an expected-waveform plan.
// Expected samples are pushed to a scoreboard queue as each cycle is driven, then
// popped and compared against the DUT on the falling edge.
module tb_trigger_pulse_shaper;
    localparam int CNT_W  = 32;
    localparam int MISS_W = 16;
    localparam int MAXC   = 64;

    typedef struct {
        logic              p;
        logic              b;
        logic [MISS_W-1:0] m;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    trigger_pulse_shaper_if #(.CNT_W(CNT_W), .MISS_W(MISS_W)) bus ();

    trigger_pulse_shaper #(.CNT_W(CNT_W), .MISS_W(MISS_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t              exp_q[$];
    int                checks = 0;
    int                errors = 0;
    logic [MISS_W-1:0] exp_missed;

    bit trig_s [MAXC];
    bit arm_s  [MAXC];
    bit upd_s  [MAXC];
    bit exp_p  [MAXC];
    bit exp_b  [MAXC];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_plan();
        for (int c = 0; c < MAXC; c++) begin
            trig_s[c] = 1'b0;
            arm_s[c]  = 1'b1;
            upd_s[c]  = 1'b0;
            exp_p[c]  = 1'b0;
            exp_b[c]  = 1'b0;
        end
    endtask

    // Expected waveform of one accepted sequence (trigger at t, effective parameters).
    task automatic add_seq(input int t, input int w, input int h, input int n, input int g);
        int last;
        for (int k = 0; k < n; k++)
            for (int i = 0; i < w; i++)
                if (t + 1 + k * (w + g) + i < MAXC) exp_p[t + 1 + k * (w + g) + i] = 1'b1;
        last = t + n * w + (n - 1) * g + h;
        for (int c = t + 1; c <= last && c < MAXC; c++) exp_b[c] = 1'b1;
    endtask

    task automatic set_cfg(input int w, input int h, input int n, input int g);
        tick();
        bus.i_cfg_width       = CNT_W'(w);
        bus.i_cfg_holdoff     = CNT_W'(h);
        bus.i_cfg_burst_count = 8'(n);
        bus.i_cfg_burst_gap   = CNT_W'(g);
        bus.i_cfg_update      = 1'b1;
        tick();
        bus.i_cfg_update      = 1'b0;
    endtask

    task automatic run_plan(input string name, input int len);
        exp_t              e;
        exp_t              got;
        logic [MISS_W-1:0] m;
        m = exp_missed;
        for (int c = 0; c < len; c++) begin
            tick();
            bus.i_trig_in    = trig_s[c];
            bus.i_arm_en     = arm_s[c];
            bus.i_cfg_update = upd_s[c];
            e.p = exp_p[c];
            e.b = exp_b[c];
            e.m = m;
            exp_q.push_back(e);
            if (trig_s[c] && exp_b[c] && m != '1) m = m + MISS_W'(1);
            @(negedge clk);
            got = exp_q.pop_front();
            checks++;
            if (bus.o_pulse_out !== got.p) begin
                errors++;
                $display("FAIL %s pulse_out cycle %0d: got %b expected %b", name, c, bus.o_pulse_out, got.p);
            end
            checks++;
            if (bus.o_busy !== got.b) begin
                errors++;
                $display("FAIL %s busy cycle %0d: got %b expected %b", name, c, bus.o_busy, got.b);
            end
            checks++;
            if (bus.o_missed_count !== got.m) begin
                errors++;
                $display("FAIL %s missed_count cycle %0d: got %0d expected %0d", name, c, bus.o_missed_count, got.m);
            end
        end
        tick();
        bus.i_trig_in    = 1'b0;
        bus.i_arm_en     = 1'b1;
        bus.i_cfg_update = 1'b0;
        exp_missed = m;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_trig_in = 1'b0;  bus.i_arm_en = 1'b1;
        bus.i_cfg_width = '0;  bus.i_cfg_holdoff = '0;
        bus.i_cfg_burst_count = 8'd0;  bus.i_cfg_burst_gap = '0;
        bus.i_cfg_update = 1'b0;  bus.i_clr_missed = 1'b0;
        tick(); tick();
        @(negedge clk);
        checks++;
        if (bus.o_pulse_out !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_missed_count !== '0) begin
            errors++;
            $display("FAIL reset: got pulse %b busy %b missed %0d expected 0 0 0",
                     bus.o_pulse_out, bus.o_busy, bus.o_missed_count);
        end
        tick();
        rst = 1'b0;
        exp_missed = '0;
    endtask

    task automatic test_single();
        set_cfg(5, 0, 1, 1);
        clear_plan();
        trig_s[10] = 1'b1;
        add_seq(10, 5, 0, 1, 1);
        run_plan("single", 20);
    endtask

    task automatic test_width_zero();
        set_cfg(0, 0, 1, 1);
        clear_plan();
        trig_s[10] = 1'b1;  trig_s[12] = 1'b1;
        add_seq(10, 1, 0, 1, 1);
        add_seq(12, 1, 0, 1, 1);
        run_plan("width_zero", 16);
    endtask

    task automatic test_holdoff_miss();
        set_cfg(3, 4, 1, 1);
        clear_plan();
        trig_s[10] = 1'b1;  trig_s[16] = 1'b1;  trig_s[18] = 1'b1;
        add_seq(10, 3, 4, 1, 1);
        add_seq(18, 3, 4, 1, 1);
        run_plan("holdoff_miss", 30);
    endtask

    task automatic test_burst();
        set_cfg(2, 0, 3, 3);
        clear_plan();
        trig_s[0] = 1'b1;
`ifdef TRIGGER_PULSE_BURST_EN
        add_seq(0, 2, 0, 3, 3);
`else
        add_seq(0, 2, 0, 1, 1);
`endif
        run_plan("burst", 20);
    endtask

    task automatic test_shadowing();
        set_cfg(10, 0, 1, 1);
        bus.i_cfg_width = CNT_W'(2);
        clear_plan();
        trig_s[0] = 1'b1;  upd_s[4] = 1'b1;  trig_s[20] = 1'b1;
        add_seq(0, 10, 0, 1, 1);
        add_seq(20, 2, 0, 1, 1);
        run_plan("shadowing", 26);
    endtask

    task automatic test_arm();
        set_cfg(3, 2, 1, 1);
        clear_plan();
        for (int c = 0; c < 5; c++) arm_s[c] = 1'b0;
        trig_s[2] = 1'b1;
        trig_s[8] = 1'b1;
        for (int c = 9; c < 20; c++) arm_s[c] = 1'b0;
        trig_s[10] = 1'b1;
        add_seq(8, 3, 2, 1, 1);
        run_plan("arm", 20);
    endtask

    task automatic test_back_to_back();
        set_cfg(2, 1, 1, 1);
        clear_plan();
        trig_s[0] = 1'b1;  trig_s[3] = 1'b1;  trig_s[4] = 1'b1;  trig_s[8] = 1'b1;
        add_seq(0, 2, 1, 1, 1);
        add_seq(4, 2, 1, 1, 1);
        add_seq(8, 2, 1, 1, 1);
        run_plan("back_to_back", 16);
    endtask

    task automatic test_saturation_reset();
        set_cfg(65545, 0, 1, 1);
        tick();
        bus.i_trig_in = 1'b1;
        for (int c = 0; c < 65538; c++) tick();
        bus.i_trig_in = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.o_missed_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL saturation: got %h expected ffff", bus.o_missed_count);
        end
        tick();
        bus.i_trig_in = 1'b1;  bus.i_clr_missed = 1'b1;
        tick();
        bus.i_trig_in = 1'b0;  bus.i_clr_missed = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.o_missed_count !== '0) begin
            errors++;
            $display("FAIL clr_vs_miss: got %0d expected 0", bus.o_missed_count);
        end
        tick();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.o_pulse_out !== 1'b1 || bus.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_pulse: got pulse %b busy %b expected 1 1", bus.o_pulse_out, bus.o_busy);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.o_pulse_out !== 1'b0 || bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_pulse_reset: got pulse %b busy %b expected 0 0", bus.o_pulse_out, bus.o_busy);
        end
        exp_missed = '0;
        clear_plan();
        trig_s[1] = 1'b1;
        add_seq(1, 1, 0, 1, 1);
        run_plan("after_reset_defaults", 6);
    endtask

    initial begin
        test_reset();
        test_single();
        test_width_zero();
        test_holdoff_miss();
        test_burst();
        test_shadowing();
        test_arm();
        test_back_to_back();
        test_saturation_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
